vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised successor of the fixed VGA sync generator. Produces hcount/vcount, data-enable, polarity-programmable hsync/vsync, and line/frame start strobes. Supports a programmable pixel-clock divider. Timing reconfiguration is double-buffered so a new mode takes effect only at a frame boundary, never mid-frame. Sits between the register interface and the pixel pipeline/VGA DAC.

Parameters:
H_W, 12, width of horizontal timing fields and hcount
V_W, 11, width of vertical timing fields and vcount
DIV_W, 4, width of pixel divider field
DEF_HD/HF/HR/HB, 640/16/96/48, horizontal timing active after reset
DEF_VD/VF/VR/VB, 480/10/2/33, vertical timing active after reset
DEF_HPOL, 0, reset hsync polarity (0 = active-low pulse)
DEF_VPOL, 0, reset vsync polarity (0 = active-low pulse)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
en_i  in  1  run enable; low holds generator idle
hd_i, hf_i, hr_i, hb_i  in  H_W each  display, front porch, sync, back porch (pixels)
vd_i, vf_i, vr_i, vb_i  in  V_W each  same fields, in lines
hpol_i, vpol_i  in  1 each  sync polarity (1 = active-high pulse)
div_i  in  DIV_W  pixel advances every div_i+1 clocks
cfg_we_i  in  1  write config fields into the pending set
cfg_pending_o  out  1  pending config is waiting for the frame boundary
cfg_err_o  out  1  one-cycle pulse: last write was rejected
hcount_o  out  H_W  current pixel column
vcount_o  out  V_W  current line
de_o  out  1  current pixel is in the display area
hs_o, vs_o  out  1 each  sync outputs at the programmed polarity
pix_ce_o  out  1  high in the first clk of each new pixel
line_start_o  out  1  one-clk pulse when hcount_o becomes 0
frame_start_o  out  1  one-clk pulse when (hcount_o, vcount_o) becomes (0, 0)

Behaviour:
- Reset (rst_i sampled high):
  - Active config = DEF_*; pending cleared; divider cleared.
  - Counts 0; de_o = 0; pix_ce_o, line_start_o, frame_start_o, cfg_err_o = 0.
  - hs_o = ~DEF_HPOL; vs_o = ~DEF_VPOL (inactive levels).
- Totals: HT = hd+hf+hr+hb and VT = vd+vf+vr+vb, computed at H_W+2 and V_W+2 bits.
- Config write validation:
  - A write is valid only if hd, hr, vd, vr >= 1 and HT <= 2^H_W and VT <= 2^V_W. Porch fields may be 0.
  - Invalid write: cfg_err_o pulses for 1 clk the cycle after the write; pending set unchanged.
  - Valid write: overwrites the pending set and sets cfg_pending_o on the next edge.
  - A later valid write overwrites an earlier pending one.
- Divider: div counter counts 0..div_i. A pixel step occurs when the counter is 0.
  - div_i = 0 gives a step every clk.
  - A div_i change takes effect at the next counter wrap.
- Per pixel step:
  - hcount advances 0..HT-1, then wraps to 0.
  - vcount increments on each h-wrap and wraps 0..VT-1.
  - All outputs are registered and updated on the same edge as the counts, so they describe the presented pixel. Latency is 0 relative to the counts.
- Region decode:
  - de_o = (h < hd) && (v < vd).
  - hs_o is active when hd+hf <= h < hd+hf+hr; vs_o is active when vd+vf <= v < vd+vf+vr.
  - Active level equals the respective pol bit; inactive level is its inverse.
- Strobes:
  - pix_ce_o = 1 for exactly 1 clk per pixel step.
  - line_start_o and frame_start_o are 1-clk pulses coincident with pix_ce_o.
- Frame boundary: the step from (HT-1, VT-1) to (0, 0).
  - If a config is pending, it is copied into the active set on that edge and cfg_pending_o clears.
  - Pixel (0, 0) of the new frame already uses the new timing and polarity.
  - A valid cfg_we_i on the same edge: the old pending set is applied and the new write becomes pending. No write is lost.
- en_i low:
  - Counts and divider are held at 0; de_o = 0; syncs inactive; strobes 0.
  - Any pending config is applied immediately.
- en_i rising: on the first edge that samples en_i = 1, outputs present pixel (0, 0) with pix_ce_o = line_start_o = frame_start_o = 1.
- Reset mid-frame: returns to the reset state on the next edge, regardless of en_i, cfg_we_i or pending config.
- No X on any output after reset.
- Invariants (checked by assertions):
  - Total de_o-high pixel steps per frame = hd*vd.
  - hs_o fall-to-rise spans hr pixel steps.
  - vcount changes only on a pixel step where hcount wraps to 0.

Test Plan:
- Default after reset, div 0, en 1 -> frame_start every 800*525 = 420000 clk; hs_o low for exactly 96 clk per line at h = 656..751; de_o high count per frame = 307200.
- Small mode H 8/2/3/1 (HT = 14), V 4/1/2/1 (VT = 8), pols 1, div 0, written while idle with en 0 -> applied immediately; hs_o high at h = 10..12; vs_o high for lines 5..6; frame period 112 clk.
- Mid-frame write of the small mode while running default at v = 100 -> cfg_pending_o = 1 until the (799, 524)->(0, 0) step; first pixel of the next frame uses HT = 14; no partial-frame glitch.
- Invalid write (hd = 0, or HT = 4097 with H_W = 12) -> cfg_err_o = 1 for one clk; cfg_pending_o and active timing unchanged.
- div_i = 2 with the small mode -> pix_ce_o every 3 clk; counts hold for 3 clk each; frame period 336 clk; strobes 1 clk wide.
- rst_i asserted at (h = 5, v = 3) with a write pending -> next edge: counts 0, de_o 0, syncs at DEF inactive levels, cfg_pending_o 0, DEF timing active.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator: pixel divider, h/v counters, region decode
// and double-buffered mode changes that only land on a frame boundary.
module vga_timing_gen #(
  parameter int H_W      = 12,
  parameter int V_W      = 11,
  parameter int DIV_W    = 4,
  parameter int DEF_HD   = 640,
  parameter int DEF_HF   = 16,
  parameter int DEF_HR   = 96,
  parameter int DEF_HB   = 48,
  parameter int DEF_VD   = 480,
  parameter int DEF_VF   = 10,
  parameter int DEF_VR   = 2,
  parameter int DEF_VB   = 33,
  parameter bit DEF_HPOL = 1'b0,
  parameter bit DEF_VPOL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [H_W-1:0]   hd_i,
  input  logic [H_W-1:0]   hf_i,
  input  logic [H_W-1:0]   hr_i,
  input  logic [H_W-1:0]   hb_i,
  input  logic [V_W-1:0]   vd_i,
  input  logic [V_W-1:0]   vf_i,
  input  logic [V_W-1:0]   vr_i,
  input  logic [V_W-1:0]   vb_i,
  input  logic             hpol_i,
  input  logic             vpol_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             cfg_we_i,
  output logic             cfg_pending_o,
  output logic             cfg_err_o,
  output logic [H_W-1:0]   hcount_o,
  output logic [V_W-1:0]   vcount_o,
  output logic             de_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             pix_ce_o,
  output logic             line_start_o,
  output logic             frame_start_o
);

  typedef struct packed {
    logic [H_W-1:0] hd, hf, hr, hb;
    logic [V_W-1:0] vd, vf, vr, vb;
    logic           hpol, vpol;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{hd: H_W'(DEF_HD), hf: H_W'(DEF_HF), hr: H_W'(DEF_HR),
                               hb: H_W'(DEF_HB), vd: V_W'(DEF_VD), vf: V_W'(DEF_VF),
                               vr: V_W'(DEF_VR), vb: V_W'(DEF_VB),
                               hpol: DEF_HPOL, vpol: DEF_VPOL};
  localparam logic [H_W+1:0] H_LIM = {2'b01, {H_W{1'b0}}};
  localparam logic [V_W+1:0] V_LIM = {2'b01, {V_W{1'b0}}};

  cfg_t             act_q, act_d, pend_q, pend_d, wr_cfg;
  logic             pend_v_q, pend_v_d, err_q, err_d, run_q, run_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [H_W-1:0]   h_q, h_d;
  logic [V_W-1:0]   v_q, v_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic             ce_q, ce_d, ls_q, ls_d, fs_q, fs_d;

  logic [H_W+1:0]   wr_ht, act_ht, hx, hs_beg, hs_end;
  logic [V_W+1:0]   wr_vt, act_vt, vx, vs_beg, vs_end;
  logic             wr_ok, step, h_last, v_last, frame_step, apply;

  assign wr_cfg = '{hd: hd_i, hf: hf_i, hr: hr_i, hb: hb_i,
                    vd: vd_i, vf: vf_i, vr: vr_i, vb: vb_i,
                    hpol: hpol_i, vpol: vpol_i};
  assign wr_ht  = (H_W+2)'(hd_i) + (H_W+2)'(hf_i) + (H_W+2)'(hr_i) + (H_W+2)'(hb_i);
  assign wr_vt  = (V_W+2)'(vd_i) + (V_W+2)'(vf_i) + (V_W+2)'(vr_i) + (V_W+2)'(vb_i);
  assign wr_ok  = (|hd_i) && (|hr_i) && (|vd_i) && (|vr_i) && (wr_ht <= H_LIM) && (wr_vt <= V_LIM);
  assign act_ht = (H_W+2)'(act_q.hd) + (H_W+2)'(act_q.hf) + (H_W+2)'(act_q.hr) + (H_W+2)'(act_q.hb);
  assign act_vt = (V_W+2)'(act_q.vd) + (V_W+2)'(act_q.vf) + (V_W+2)'(act_q.vr) + (V_W+2)'(act_q.vb);

  always_comb begin
    step       = en_i && (cnt_q == '0);
    h_last     = ({2'b00, h_q} == act_ht - (H_W+2)'(1));
    v_last     = ({2'b00, v_q} == act_vt - (V_W+2)'(1));
    // The first step after enabling also starts a frame, so it may apply pending timing.
    frame_step = step && (!run_q || (h_last && v_last));
    apply      = pend_v_q && (!en_i || frame_step);

    act_d    = apply ? pend_q : act_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q && !apply;
    if (cfg_we_i && wr_ok) begin
      pend_d   = wr_cfg;
      pend_v_d = 1'b1;
    end
    err_d = cfg_we_i && !wr_ok;

    cnt_d = cnt_q;
    div_d = div_q;
    if (!en_i || (cnt_q == div_q)) begin
      cnt_d = '0;
      div_d = div_i;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    run_d = en_i;
    h_d   = h_q;
    v_d   = v_q;
    if (!en_i) begin
      h_d = '0;
      v_d = '0;
    end else if (step) begin
      if (!run_q || h_last) begin
        h_d = '0;
        v_d = (!run_q || v_last) ? '0 : v_q + V_W'(1);
      end else begin
        h_d = h_q + H_W'(1);
      end
    end

    // Decode against the timing that will be active for the presented pixel.
    hx     = (H_W+2)'(h_d);
    vx     = (V_W+2)'(v_d);
    hs_beg = (H_W+2)'(act_d.hd) + (H_W+2)'(act_d.hf);
    hs_end = hs_beg + (H_W+2)'(act_d.hr);
    vs_beg = (V_W+2)'(act_d.vd) + (V_W+2)'(act_d.vf);
    vs_end = vs_beg + (V_W+2)'(act_d.vr);
    de_d   = en_i && (h_d < act_d.hd) && (v_d < act_d.vd);
    hs_d   = (en_i && (hx >= hs_beg) && (hx < hs_end)) ? act_d.hpol : ~act_d.hpol;
    vs_d   = (en_i && (vx >= vs_beg) && (vx < vs_end)) ? act_d.vpol : ~act_d.vpol;
    ce_d   = step;
    ls_d   = step && (h_d == '0);
    fs_d   = step && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q    <= DEF_CFG;
      pend_q   <= DEF_CFG;
      pend_v_q <= 1'b0;
      err_q    <= 1'b0;
      run_q    <= 1'b0;
      cnt_q    <= '0;
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      de_q     <= 1'b0;
      hs_q     <= ~DEF_HPOL;
      vs_q     <= ~DEF_VPOL;
      ce_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      act_q    <= act_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      err_q    <= err_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ce_q     <= ce_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign cfg_pending_o = pend_v_q;
  assign cfg_err_o     = err_q;
  assign hcount_o      = h_q;
  assign vcount_o      = v_q;
  assign de_o          = de_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign pix_ce_o      = ce_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed mode/divider/reset steps plus random
// config traffic, checked every clock against an arithmetic frame model.
module tb_vga_timing_gen;
  localparam int H_W = 12;
  localparam int V_W = 11;
  localparam int DIV_W = 4;

  typedef struct packed {
    int hd; int hf; int hr; int hb;
    int vd; int vf; int vr; int vb;
    int hp; int vp;
  } mcfg_t;

  localparam mcfg_t DEF_M  = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
  localparam mcfg_t SMALL  = '{8, 2, 3, 1, 4, 1, 2, 1, 1, 1};
  localparam mcfg_t MODE_A = '{20, 3, 4, 5, 10, 2, 3, 2, 0, 1};
  localparam mcfg_t MODE_B = '{5, 1, 1, 1, 3, 1, 1, 1, 1, 0};
  localparam mcfg_t BAD_HD = '{0, 2, 3, 1, 4, 1, 2, 1, 1, 1};
  localparam mcfg_t BAD_HT = '{4000, 50, 40, 7, 4, 1, 2, 1, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, en, we, hpol, vpol;
  logic [H_W-1:0]   hd, hf, hr, hb;
  logic [V_W-1:0]   vd, vf, vr, vb;
  logic [DIV_W-1:0] div;
  logic             pend_o, err_o, de_o, hs_o, vs_o, ce_o, ls_o, fs_o;
  logic [H_W-1:0]   hcount;
  logic [V_W-1:0]   vcount;

  vga_timing_gen dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .hd_i(hd), .hf_i(hf), .hr_i(hr), .hb_i(hb),
    .vd_i(vd), .vf_i(vf), .vr_i(vr), .vb_i(vb),
    .hpol_i(hpol), .vpol_i(vpol), .div_i(div), .cfg_we_i(we),
    .cfg_pending_o(pend_o), .cfg_err_o(err_o),
    .hcount_o(hcount), .vcount_o(vcount),
    .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
    .pix_ce_o(ce_o), .line_start_o(ls_o), .frame_start_o(fs_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pixel position derived from elapsed clocks since frame start.
  mcfg_t m_act, m_pend;
  int    m_pv, m_run, t, fs_t, dd;
  int    e_h, e_v, e_de, e_hs, e_vs, e_ce, e_ls, e_fs, e_err;

  function automatic int ht(mcfg_t c); return c.hd + c.hf + c.hr + c.hb; endfunction
  function automatic int vt(mcfg_t c); return c.vd + c.vf + c.vr + c.vb; endfunction
  function automatic int valid(mcfg_t c);
    return (c.hd >= 1 && c.hr >= 1 && c.vd >= 1 && c.vr >= 1 &&
            ht(c) <= 4096 && vt(c) <= 2048) ? 1 : 0;
  endfunction

  function automatic mcfg_t cur_cfg();
    mcfg_t c;
    c.hd = int'(hd); c.hf = int'(hf); c.hr = int'(hr); c.hb = int'(hb);
    c.vd = int'(vd); c.vf = int'(vf); c.vr = int'(vr); c.vb = int'(vb);
    c.hp = int'(hpol); c.vp = int'(vpol);
    return c;
  endfunction

  function automatic mcfg_t rand_cfg();
    mcfg_t c;
    c.hd = int'($urandom_range(1, 6)); c.hf = int'($urandom_range(0, 3));
    c.hr = int'($urandom_range(1, 3)); c.hb = int'($urandom_range(0, 3));
    c.vd = int'($urandom_range(1, 4)); c.vf = int'($urandom_range(0, 2));
    c.vr = int'($urandom_range(1, 2)); c.vb = int'($urandom_range(0, 2));
    c.hp = int'($urandom_range(0, 1)); c.vp = int'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: c.hd = 0;
      1: c.vr = 0;
      2: c.hf = 4095;
      default: ;
    endcase
    return c;
  endfunction

  task automatic set_cfg(input mcfg_t c);
    hd = H_W'(c.hd); hf = H_W'(c.hf); hr = H_W'(c.hr); hb = H_W'(c.hb);
    vd = V_W'(c.vd); vf = V_W'(c.vf); vr = V_W'(c.vr); vb = V_W'(c.vb);
    hpol = c.hp[0]; vpol = c.vp[0];
  endtask

  task automatic model_step();
    mcfg_t wr;
    int    bnd, el, p;
    if (rst) begin
      m_act = DEF_M; m_pv = 0; m_run = 0;
      e_h = 0; e_v = 0; e_de = 0; e_hs = 1; e_vs = 1;
      e_ce = 0; e_ls = 0; e_fs = 0; e_err = 0;
    end else begin
      wr    = cur_cfg();
      e_err = (we && valid(wr) == 0) ? 1 : 0;
      bnd   = 0;
      if (!en) begin
        m_run = 0; bnd = 1;
      end else if (m_run == 0) begin
        m_run = 1; t = 0; fs_t = 0; dd = int'(div) + 1; bnd = 1;
      end else begin
        t = t + 1;
        if (t - fs_t == ht(m_act) * vt(m_act) * dd) begin
          fs_t = t; bnd = 1;
        end
      end
      if (bnd == 1 && m_pv == 1) begin m_act = m_pend; m_pv = 0; end
      if (we && valid(wr) == 1) begin m_pend = wr; m_pv = 1; end
      if (!en) begin
        e_h = 0; e_v = 0; e_de = 0; e_ce = 0; e_ls = 0; e_fs = 0;
        e_hs = 1 - m_act.hp; e_vs = 1 - m_act.vp;
      end else begin
        el   = t - fs_t;
        p    = el / dd;
        e_ce = (el % dd == 0) ? 1 : 0;
        e_h  = p % ht(m_act);
        e_v  = p / ht(m_act);
        e_ls = (e_ce == 1 && e_h == 0) ? 1 : 0;
        e_fs = (e_ls == 1 && e_v == 0) ? 1 : 0;
        e_de = (e_h < m_act.hd && e_v < m_act.vd) ? 1 : 0;
        e_hs = (e_h >= m_act.hd + m_act.hf && e_h < m_act.hd + m_act.hf + m_act.hr)
               ? m_act.hp : 1 - m_act.hp;
        e_vs = (e_v >= m_act.vd + m_act.vf && e_v < m_act.vd + m_act.vf + m_act.vr)
               ? m_act.vp : 1 - m_act.vp;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at t=%0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("hcount", 32'(hcount), 32'(e_h));
    chk("vcount", 32'(vcount), 32'(e_v));
    chk("de", 32'(de_o), 32'(e_de));
    chk("hs", 32'(hs_o), 32'(e_hs));
    chk("vs", 32'(vs_o), 32'(e_vs));
    chk("pix_ce", 32'(ce_o), 32'(e_ce));
    chk("line_start", 32'(ls_o), 32'(e_ls));
    chk("frame_start", 32'(fs_o), 32'(e_fs));
    chk("cfg_pending", 32'(pend_o), 32'(m_pv));
    chk("cfg_err", 32'(err_o), 32'(e_err));
    $display("cyc t=%0t h=%0d v=%0d de=%0b hs=%0b vs=%0b ce=%0b ls=%0b fs=%0b pend=%0b err=%0b",
             $time, hcount, vcount, de_o, hs_o, vs_o, ce_o, ls_o, fs_o, pend_o, err_o);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; div = '0;
    set_cfg(DEF_M);
    m_act = DEF_M; m_pend = DEF_M; m_pv = 0; m_run = 0; t = 0; fs_t = 0; dd = 1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Default 640x480 timing, two lines and a bit
    en = 1'b1;
    repeat (1700) tick();

    // Small mode written while idle is applied immediately
    en = 1'b0; we = 1'b1; set_cfg(SMALL);
    tick();
    we = 1'b0;
    tick(); tick();
    en = 1'b1;
    repeat (240) tick();

    // Rejected writes while running
    we = 1'b1; set_cfg(BAD_HD); tick();
    set_cfg(BAD_HT); tick();
    we = 1'b0;
    repeat (120) tick();

    // Divide by three
    en = 1'b0; div = 4'd2; tick(); tick();
    en = 1'b1;
    repeat (700) tick();

    // Mid-frame writes: second overwrites first, lands at the frame boundary
    en = 1'b0; div = '0; we = 1'b1; set_cfg(MODE_A); tick();
    we = 1'b0; tick();
    en = 1'b1;
    for (int i = 0; i < 2000 && !(e_v == 8 && e_h == 0); i++) tick();
    chk("reach_v8", 32'(e_v == 8), 32'd1);
    we = 1'b1; set_cfg(MODE_B); tick();
    set_cfg(SMALL); tick();
    we = 1'b0;
    repeat (700) tick();

    // Reset mid-frame with a write pending
    for (int i = 0; i < 500 && !(e_h == 5 && e_v == 3); i++) tick();
    chk("reach_h5v3", 32'(e_h == 5 && e_v == 3), 32'd1);
    we = 1'b1; set_cfg(MODE_A); tick();
    we = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    repeat (50) tick();

    // Random config traffic with occasional idle cycles and divider changes
    for (int i = 0; i < 6000; i++) begin
      we = 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        we = 1'b1;
        set_cfg(rand_cfg());
      end
      if (en && $urandom_range(0, 999) == 0) begin
        en = 1'b0;
        div = DIV_W'($urandom_range(0, 3));
      end else begin
        en = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
